// File: rtl/arm_pipelined_pkg.sv
// rtl/arm_pipelined_pkg.sv - shared types and constants for the ARM pipelined core
package arm_pipelined_pkg;

    typedef struct packed {
        logic       PCSrc;
        logic       RegWrite;
        logic       MemToReg;
        logic       MemWrite;
        logic       Branch;
        logic       ALUSrc;
        logic [1:0] ALUControl;
        logic [1:0] FlagWrite;
        logic [1:0] ImmSrc;
        logic [3:0] Cond;
    } decode_ctrl_t;

    localparam logic [3:0]   PC_REG_ADDR = 4'hF;
    localparam decode_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/arm_pipelined_wb_bypass.sv
// rtl/arm_pipelined_wb_bypass.sv - writeback-to-operand bypass compare and mux
module arm_pipelined_wb_bypass
    import arm_pipelined_pkg::*;
#(
    parameter int BusWidth     = 32,
    parameter int RegAddrWidth = 4
) (
    input  logic                    i_Enable,
    input  logic                    i_W_RegWrite,
    input  logic [RegAddrWidth-1:0] i_W_WA3,
    input  logic [BusWidth-1:0]     i_W_Result,
    input  logic [RegAddrWidth-1:0] i_RA,
    input  logic [BusWidth-1:0]     i_RD,
    output logic [BusWidth-1:0]     o_RD
);

    localparam logic [RegAddrWidth-1:0] PC_ADDR = RegAddrWidth'(PC_REG_ADDR);

    // R15 reads come from the PC path, so a write to R15 never replaces them
    logic w_hit;
    assign w_hit = i_Enable && i_W_RegWrite && (i_W_WA3 == i_RA) && (i_RA != PC_ADDR);
    assign o_RD  = w_hit ? i_W_Result : i_RD;

endmodule

// File: rtl/arm_pipelined_decode_execute_register.sv
// rtl/arm_pipelined_decode_execute_register.sv - Decode/Execute pipeline register with WB bypass, stall, flush
module arm_pipelined_decode_execute_register
    import arm_pipelined_pkg::*;
#(
    parameter int BusWidth       = 32,
    parameter int RegAddrWidth   = 4,
    parameter int BubbleCntWidth = 16
) (
    input  logic                      i_CLK,
    input  logic                      i_RESET,
    input  logic                      i_Stall,
    input  logic                      i_Flush,
    input  logic [BusWidth-1:0]       i_D_RD1,
    input  logic [BusWidth-1:0]       i_D_RD2,
    input  logic [BusWidth-1:0]       i_D_ExtImm,
    input  logic [RegAddrWidth-1:0]   i_D_RA1,
    input  logic [RegAddrWidth-1:0]   i_D_RA2,
    input  logic [RegAddrWidth-1:0]   i_D_WA3,
    input  decode_ctrl_t              i_D_Ctrl,
    input  logic                      i_W_RegWrite,
    input  logic [RegAddrWidth-1:0]   i_W_WA3,
    input  logic [BusWidth-1:0]       i_W_Result,
    output logic                      o_E_Valid,
    output logic [BusWidth-1:0]       o_E_RD1,
    output logic [BusWidth-1:0]       o_E_RD2,
    output logic [BusWidth-1:0]       o_E_ExtImm,
    output logic [RegAddrWidth-1:0]   o_E_RA1,
    output logic [RegAddrWidth-1:0]   o_E_RA2,
    output logic [RegAddrWidth-1:0]   o_E_WA3,
    output decode_ctrl_t              o_E_Ctrl,
    output logic [BubbleCntWidth-1:0] o_BubbleCount
);

    logic                      r_Valid;
    logic [BusWidth-1:0]       r_RD1, r_RD2, r_ExtImm;
    logic [RegAddrWidth-1:0]   r_RA1, r_RA2, r_WA3;
    decode_ctrl_t              r_Ctrl;
    logic [BubbleCntWidth-1:0] r_BubbleCount;

    logic [BusWidth-1:0] w_load_rd1, w_load_rd2, w_stall_rd1, w_stall_rd2;

    arm_pipelined_wb_bypass #(.BusWidth(BusWidth), .RegAddrWidth(RegAddrWidth)) u_load_bp1 (
        .i_Enable(1'b1), .i_W_RegWrite(i_W_RegWrite), .i_W_WA3(i_W_WA3), .i_W_Result(i_W_Result),
        .i_RA(i_D_RA1), .i_RD(i_D_RD1), .o_RD(w_load_rd1));
    arm_pipelined_wb_bypass #(.BusWidth(BusWidth), .RegAddrWidth(RegAddrWidth)) u_load_bp2 (
        .i_Enable(1'b1), .i_W_RegWrite(i_W_RegWrite), .i_W_WA3(i_W_WA3), .i_W_Result(i_W_Result),
        .i_RA(i_D_RA2), .i_RD(i_D_RD2), .o_RD(w_load_rd2));

    // While held, keep operands coherent with register file writes landing during the stall
    arm_pipelined_wb_bypass #(.BusWidth(BusWidth), .RegAddrWidth(RegAddrWidth)) u_stall_bp1 (
        .i_Enable(r_Valid), .i_W_RegWrite(i_W_RegWrite), .i_W_WA3(i_W_WA3), .i_W_Result(i_W_Result),
        .i_RA(r_RA1), .i_RD(r_RD1), .o_RD(w_stall_rd1));
    arm_pipelined_wb_bypass #(.BusWidth(BusWidth), .RegAddrWidth(RegAddrWidth)) u_stall_bp2 (
        .i_Enable(r_Valid), .i_W_RegWrite(i_W_RegWrite), .i_W_WA3(i_W_WA3), .i_W_Result(i_W_Result),
        .i_RA(r_RA2), .i_RD(r_RD2), .o_RD(w_stall_rd2));

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_Valid       <= 1'b0;
            r_RD1         <= '0;
            r_RD2         <= '0;
            r_ExtImm      <= '0;
            r_RA1         <= '0;
            r_RA2         <= '0;
            r_WA3         <= '0;
            r_Ctrl        <= CTRL_BUBBLE;
            r_BubbleCount <= '0;
        end else if (i_Flush) begin
            r_Valid  <= 1'b0;
            r_RD1    <= '0;
            r_RD2    <= '0;
            r_ExtImm <= '0;
            r_RA1    <= '0;
            r_RA2    <= '0;
            r_WA3    <= '0;
            r_Ctrl   <= CTRL_BUBBLE;
            if (r_BubbleCount != '1)
                r_BubbleCount <= r_BubbleCount + 1'b1;
        end else if (i_Stall) begin
            r_RD1 <= w_stall_rd1;
            r_RD2 <= w_stall_rd2;
        end else begin
            r_Valid  <= 1'b1;
            r_RD1    <= w_load_rd1;
            r_RD2    <= w_load_rd2;
            r_ExtImm <= i_D_ExtImm;
            r_RA1    <= i_D_RA1;
            r_RA2    <= i_D_RA2;
            r_WA3    <= i_D_WA3;
            r_Ctrl   <= i_D_Ctrl;
        end
    end

    assign o_E_Valid     = r_Valid;
    assign o_E_RD1       = r_RD1;
    assign o_E_RD2       = r_RD2;
    assign o_E_ExtImm    = r_ExtImm;
    assign o_E_RA1       = r_RA1;
    assign o_E_RA2       = r_RA2;
    assign o_E_WA3       = r_WA3;
    assign o_E_Ctrl      = r_Ctrl;
    assign o_BubbleCount = r_BubbleCount;

endmodule

// File: tb/tb_arm_pipelined_decode_execute_register.sv
// tb/tb_arm_pipelined_decode_execute_register.sv - directed self-checking bench for the D/E register
module tb_arm_pipelined_decode_execute_register;
    import arm_pipelined_pkg::*;

    logic         clk = 1'b0;
    logic         rst, stall, flush;
    logic [31:0]  d_rd1, d_rd2, d_imm;
    logic [3:0]   d_ra1, d_ra2, d_wa3;
    decode_ctrl_t d_ctrl;
    logic         w_we;
    logic [3:0]   w_wa3;
    logic [31:0]  w_res;
    logic         e_valid;
    logic [31:0]  e_rd1, e_rd2, e_imm;
    logic [3:0]   e_ra1, e_ra2, e_wa3;
    decode_ctrl_t e_ctrl;
    logic [3:0]   bubbles;

    int n_checks = 0;
    int n_pass   = 0;

    decode_ctrl_t c_rw, c_rwmw;

    always #5 clk = ~clk;

    arm_pipelined_decode_execute_register #(.BusWidth(32), .RegAddrWidth(4), .BubbleCntWidth(4)) dut (
        .i_CLK(clk), .i_RESET(rst), .i_Stall(stall), .i_Flush(flush),
        .i_D_RD1(d_rd1), .i_D_RD2(d_rd2), .i_D_ExtImm(d_imm),
        .i_D_RA1(d_ra1), .i_D_RA2(d_ra2), .i_D_WA3(d_wa3), .i_D_Ctrl(d_ctrl),
        .i_W_RegWrite(w_we), .i_W_WA3(w_wa3), .i_W_Result(w_res),
        .o_E_Valid(e_valid), .o_E_RD1(e_rd1), .o_E_RD2(e_rd2), .o_E_ExtImm(e_imm),
        .o_E_RA1(e_ra1), .o_E_RA2(e_ra2), .o_E_WA3(e_wa3), .o_E_Ctrl(e_ctrl),
        .o_BubbleCount(bubbles));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(e_valid), 32'd0);
        check({tag, "_rd1"},   e_rd1, 32'd0);
        check({tag, "_rd2"},   e_rd2, 32'd0);
        check({tag, "_imm"},   e_imm, 32'd0);
        check({tag, "_addr"},  {20'd0, e_ra1, e_ra2, e_wa3}, 32'd0);
        check({tag, "_ctrl"},  32'(e_ctrl), 32'd0);
    endtask

    initial begin
        c_rw   = CTRL_BUBBLE; c_rw.RegWrite = 1'b1; c_rw.Cond = 4'hE;
        c_rwmw = c_rw;        c_rwmw.MemWrite = 1'b1; c_rwmw.ALUSrc = 1'b1;

        rst = 1; stall = 0; flush = 0;
        d_rd1 = 0; d_rd2 = 0; d_imm = 0; d_ra1 = 0; d_ra2 = 0; d_wa3 = 0; d_ctrl = CTRL_BUBBLE;
        w_we = 0; w_wa3 = 0; w_res = 0;
        step();
        check_zero("reset");
        check("reset_bubbles", 32'(bubbles), 32'd0);

        // Basic load
        rst = 0;
        d_rd1 = 32'h11; d_rd2 = 32'h22; d_imm = 32'h33; d_ra1 = 4'd1; d_ra2 = 4'd2; d_wa3 = 4'd5; d_ctrl = c_rw;
        step();
        check("load_valid", 32'(e_valid), 32'd1);
        check("load_rd1",   e_rd1, 32'h11);
        check("load_rd2",   e_rd2, 32'h22);
        check("load_imm",   e_imm, 32'h33);
        check("load_addr",  {20'd0, e_ra1, e_ra2, e_wa3}, 32'h125);
        check("load_ctrl",  32'(e_ctrl), 32'(c_rw));

        rst = 1;
        step();
        check_zero("reset2");

        // Writeback bypass on load, and R15 exclusion
        rst = 0;
        d_ra1 = 4'd3; d_rd1 = 32'h0; w_we = 1; w_wa3 = 4'd3; w_res = 32'hDEADBEEF;
        step();
        check("bp_rd1",  e_rd1, 32'hDEADBEEF);
        check("bp_rd2",  e_rd2, 32'h22);
        d_ra1 = 4'd15; w_wa3 = 4'd15; d_rd1 = 32'h1234;
        step();
        check("bp_r15",  e_rd1, 32'h1234);
        d_ra1 = 4'd4; d_ra2 = 4'd4; d_rd1 = 32'h5; d_rd2 = 32'h6; w_wa3 = 4'd4; w_res = 32'h0BADF00D;
        step();
        check("bp_both1", e_rd1, 32'h0BADF00D);
        check("bp_both2", e_rd2, 32'h0BADF00D);
        d_ra1 = 4'd4; w_we = 0;
        step();
        check("bp_nowe", e_rd1, 32'h5);

        // Stall with writeback update of held RA2
        d_rd1 = 32'h101; d_rd2 = 32'h77; d_imm = 32'h99; d_ra1 = 4'd1; d_ra2 = 4'd7; d_wa3 = 4'd9; d_ctrl = c_rwmw;
        step();
        check("pre_stall_rd2", e_rd2, 32'h77);
        stall = 1;
        d_rd1 = 32'hAAAA; d_rd2 = 32'hBBBB; d_imm = 32'hCCCC; d_ra1 = 4'd2; d_ra2 = 4'd3; d_wa3 = 4'd4; d_ctrl = c_rw;
        w_we = 1; w_wa3 = 4'd7; w_res = 32'hCAFE0000;
        step();
        check("stall_rd2",   e_rd2, 32'hCAFE0000);
        check("stall_rd1",   e_rd1, 32'h101);
        check("stall_imm",   e_imm, 32'h99);
        check("stall_addr",  {20'd0, e_ra1, e_ra2, e_wa3}, 32'h179);
        check("stall_ctrl",  32'(e_ctrl), 32'(c_rwmw));
        check("stall_valid", 32'(e_valid), 32'd1);
        w_we = 0; w_res = 32'h12345678;
        step();
        check("stall_hold_rd2", e_rd2, 32'hCAFE0000);

        // Flush wins over stall
        stall = 0; d_ctrl = c_rwmw;
        step();
        check("pre_flush_valid", 32'(e_valid), 32'd1);
        flush = 1; stall = 1;
        step();
        check("flush_valid",    32'(e_valid), 32'd0);
        check("flush_regwrite", 32'(e_ctrl.RegWrite), 32'd0);
        check("flush_memwrite", 32'(e_ctrl.MemWrite), 32'd0);
        check("flush_rd1",      e_rd1, 32'd0);
        check("flush_bubbles",  32'(bubbles), 32'd1);

        // Saturation of the 4-bit counter
        stall = 0;
        for (int k = 2; k <= 21; k++) begin
            step();
            check($sformatf("sat_%0d", k), 32'(bubbles), (k > 15) ? 32'd15 : 32'(k));
        end

        // Reset during flush, then first load right after
        rst = 1;
        step();
        check("rst_flush_bubbles", 32'(bubbles), 32'd0);
        check_zero("rst_flush");
        rst = 0; flush = 0;
        step();
        check("post_rst_valid", 32'(e_valid), 32'd1);
        check("post_rst_rd2",   e_rd2, 32'hBBBB);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/arm_pipelined_decode_execute_register.md
# arm_pipelined_decode_execute_register

Decode→Execute pipeline register of the ARM pipelined core. It captures the register file read ports, extended immediate, register addresses and decoded control at the Decode/Execute boundary. It corrects the register file's same-cycle write/read hazard with a Writeback→Decode bypass. It also implements stall (hold) and flush (bubble insertion) under hazard-unit control, and counts inserted bubbles.

## Interface
Parameters:
- BusWidth, 32, datapath width
- RegAddrWidth, 4, register address width
- BubbleCntWidth, 16, width of saturating bubble counter

Ports:
- i_CLK  in  1  core clock, all state on rising edge
- i_RESET  in  1  synchronous, active-high reset
- i_Stall  in  1  hold all stored state this cycle
- i_Flush  in  1  load a bubble this cycle
- i_D_RD1, i_D_RD2  in  BusWidth  register file outputs 1/2
- i_D_ExtImm  in  BusWidth  extended immediate
- i_D_RA1, i_D_RA2, i_D_WA3  in  RegAddrWidth  source/destination addresses
- i_D_Ctrl  in  decode_ctrl_t  decoded control bundle
- i_W_RegWrite  in  1  writeback write enable (same signal driving register file write enable)
- i_W_WA3  in  RegAddrWidth  writeback destination
- i_W_Result  in  BusWidth  writeback data
- o_E_Valid  out  1  stage holds a real instruction
- o_E_RD1, o_E_RD2, o_E_ExtImm  out  BusWidth  registered operands
- o_E_RA1, o_E_RA2, o_E_WA3  out  RegAddrWidth  registered addresses (feed forwarding unit)
- o_E_Ctrl  out  decode_ctrl_t  registered control
- o_BubbleCount  out  BubbleCntWidth  saturating count of flush cycles

## Operation
- Per-edge priority: i_RESET > i_Flush > i_Stall > load.
- Load: all fields take their i_D_* value; o_E_Valid=1.
- Bypass on load: if i_W_RegWrite && i_W_WA3==i_D_RA1 && i_D_RA1!=4'hF, capture i_W_Result into RD1. Otherwise capture i_D_RD1. Same rule for RD2/RA2. R15 is never bypassed; its read value comes from the PC path.
- Flush: o_E_Valid=0. Clear Ctrl fields RegWrite, MemWrite, Branch, PCSrc and FlagWrite to 0. Zero the data and address fields. o_BubbleCount increments unless already all-ones, where it saturates.
- Stall: every field holds, with one exception. If o_E_Valid && i_W_RegWrite && i_W_WA3==o_E_RA1 && o_E_RA1!=4'hF, RD1 updates to i_W_Result. Same rule for RD2. This keeps held operands coherent with a register file updated during the stall.
- Flush and stall asserted together: flush wins and a bubble is loaded.
- Reset: all outputs 0, including o_E_Valid, o_E_Ctrl and o_BubbleCount.

## Timing
- Latency: exactly 1 cycle from i_D_* to o_E_*. No combinational path from any input to any output.
- Bypass compare is combinational on inputs and is registered.
- i_W_* sampled on the same edge the register file commits the write, so the captured value equals post-write register contents.
- Reset asserted mid-stall or mid-flush: the next edge yields all zeros. The first load is accepted on the first edge with i_RESET low.
- Counter saturates at 2^BubbleCntWidth−1. It never wraps.

## Structure
- Shared package arm_pipelined_pkg:
  - decode_ctrl_t packed struct: PCSrc, RegWrite, MemToReg, MemWrite, Branch, ALUSrc, ALUControl[1:0], FlagWrite[1:0], ImmSrc[1:0], Cond[3:0].
  - PC_REG_ADDR = 4'hF.
  - CTRL_BUBBLE constant (all-zero decode_ctrl_t).
- One sub-module: arm_pipelined_wb_bypass. It holds the combinational compare/mux and is instantiated twice for load and twice for stall paths, or shared by muxing the compare address.

## Test plan
- Reset, then load RD1=0x11, RD2=0x22, ExtImm=0x33, WA3=5, RegWrite=1 → after 1 edge outputs match, o_E_Valid=1; assert reset → all outputs 0 next edge.
- Load RA1=3 with W_RegWrite=1, W_WA3=3, W_Result=0xDEADBEEF, i_D_RD1=0x0 → o_E_RD1=0xDEADBEEF; repeat with RA1=15, W_WA3=15 → o_E_RD1=i_D_RD1.
- Load instruction with RA2=7 and assert i_Stall. A write of 7←0xCAFE0000 during the stall → o_E_RD2=0xCAFE0000. Other fields unchanged.
- Assert i_Flush and i_Stall together on a valid RegWrite/MemWrite instruction → o_E_Valid=0, Ctrl.RegWrite=0, Ctrl.MemWrite=0, o_BubbleCount=1.
- With BubbleCntWidth=4, flush 20 consecutive cycles → o_BubbleCount=15, held at 15.
